// File: rtl/cpu_3_jtag_debug_mon_ctrl.sv
// rtl/cpu_3_jtag_debug_mon_ctrl.sv - sysclk-side JTAG debug monitor control and RAM access sequencer
module cpu_3_jtag_debug_mon_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              debugack,
    input  logic              cpu_reset_taken,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              debugreq,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic              resetlatch,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       dreg_q, dreg_d;
    logic              ready_q, ready_d;
    logic              error_q, error_d;
    logic              rlatch_q, rlatch_d;
    logic              dbgreq_q, dbgreq_d;
    logic [15:0]       cnt_q, cnt_d;

    logic unused_jdo;
    assign unused_jdo = ^{jdo[37], jdo[2:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            dreg_q   <= '0;
            ready_q  <= 1'b0;
            error_q  <= 1'b0;
            rlatch_q <= 1'b0;
            dbgreq_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            dreg_q   <= dreg_d;
            ready_q  <= ready_d;
            error_q  <= error_d;
            rlatch_q <= rlatch_d;
            dbgreq_q <= dbgreq_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        dreg_d   = dreg_q;
        ready_d  = ready_q;
        error_d  = error_q;
        rlatch_d = rlatch_q;
        dbgreq_d = dbgreq_q;
        cnt_d    = cnt_q;

        // Later assignments take priority: set beats auto-clear, explicit clear beats set.
        if (debugack)                         dbgreq_d = 1'b0;
        if (take_action_ocimem_a && jdo[34])  dbgreq_d = 1'b1;
        if (take_action_ocimem_a && jdo[33])  dbgreq_d = 1'b0;
        if (take_action_ocimem_a && jdo[32])  error_d  = 1'b0;
        if (take_action_ocimem_a && jdo[31])  rlatch_d = 1'b0;
        if (cpu_reset_taken)                  rlatch_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (take_action_ocimem_a && jdo[35]) addr_d = jdo[ADDR_W+9:10];
                if (take_action_ocimem_b) begin
                    state_d = REQ;
                    we_d    = jdo[36];
                    if (jdo[36]) wdata_d = jdo[34:3];
                    ready_d = 1'b0;
                    cnt_d   = '0;
                end
            end
            REQ: begin
                if (take_action_ocimem_b) error_d = 1'b1;
                // An ack on the final counted cycle still wins over the timeout.
                if (mem_ack) begin
                    state_d = DONE;
                    if (!we_q) dreg_d = mem_rdata;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DONE: begin
                if (take_action_ocimem_b) error_d = 1'b1;
                ready_d = 1'b1;
                addr_d  = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_req       = (state_q == REQ);
    assign busy          = (state_q != IDLE);
    assign mem_we        = we_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign MonDReg       = dreg_q;
    assign monitor_ready = ready_q;
    assign monitor_error = error_q;
    assign resetlatch    = rlatch_q;
    assign debugreq      = dbgreq_q;

endmodule
